// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and default widths.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_FILE_ADDR_LEN = 4;
    localparam int unsigned PERF_CNT_LEN      = 16;

    typedef enum logic [0:0] {
        StRun     = 1'b0,
        StMemWait = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Event counter that clears on synchronous reset and sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Freeze/flush sequencing for the 5-stage pipeline: memory waits, taken branches and RAW
// hazards, plus saturating stall/bubble/flush event counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_FILE_ADDR_LEN,
    parameter int unsigned CNT_W      = PERF_CNT_LEN
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  forward_en_i,
    input  logic [REG_ADDR_W-1:0] id_src1_i,
    input  logic [REG_ADDR_W-1:0] id_src2_i,
    input  logic                  id_two_src_i,
    input  logic                  id_uses_src1_i,
    input  logic [REG_ADDR_W-1:0] exe_dest_i,
    input  logic                  exe_wb_en_i,
    input  logic                  exe_mem_read_i,
    input  logic [REG_ADDR_W-1:0] mem_dest_i,
    input  logic                  mem_wb_en_i,
    input  logic                  branch_taken_i,
    input  logic                  mem_rd_en_i,
    input  logic                  mem_wr_en_i,
    input  logic                  mem_ready_i,
    output logic                  freeze_if_o,
    output logic                  freeze_id_o,
    output logic                  stall_all_o,
    output logic                  flush_if_o,
    output logic                  bubble_id_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      bubble_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
);

    ctrl_state_e state_q;

    logic mem_access;
    logic src1_exe, src1_mem, src2_exe, src2_mem;
    logic src1_hit, src2_hit;
    logic raw_hazard;
    logic inc_bubble;

    assign mem_access = mem_rd_en_i | mem_wr_en_i;

    assign src1_exe = exe_wb_en_i && (id_src1_i == exe_dest_i);
    assign src1_mem = mem_wb_en_i && (id_src1_i == mem_dest_i);
    assign src2_exe = exe_wb_en_i && (id_src2_i == exe_dest_i);
    assign src2_mem = mem_wb_en_i && (id_src2_i == mem_dest_i);

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign src1_hit = forward_en_i ? (src1_exe && exe_mem_read_i) : (src1_exe || src1_mem);
    assign src2_hit = forward_en_i ? (src2_exe && exe_mem_read_i) : (src2_exe || src2_mem);

    assign raw_hazard = (id_uses_src1_i && src1_hit) || (id_two_src_i && src2_hit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
        end else begin
            case (state_q)
                StRun:     if (mem_access && !mem_ready_i) state_q <= StMemWait;
                StMemWait: if (mem_ready_i) state_q <= StRun;
                default:   state_q <= StRun;
            endcase
        end
    end

    always_comb begin
        stall_all_o = 1'b0;
        freeze_if_o = 1'b0;
        freeze_id_o = 1'b0;
        flush_if_o  = 1'b0;
        bubble_id_o = 1'b0;
        inc_bubble  = 1'b0;
        if (!rst_i) begin
            if (state_q == StMemWait) begin
                stall_all_o = !mem_ready_i;
            end else begin
                stall_all_o = mem_access && !mem_ready_i;
            end

            if (stall_all_o) begin
                freeze_if_o = 1'b1;
                freeze_id_o = 1'b1;
            end else if (branch_taken_i) begin
                // Branch wins over a hazard: the ID instruction is wrong-path anyway.
                flush_if_o  = 1'b1;
                bubble_id_o = 1'b1;
            end else if (raw_hazard) begin
                freeze_if_o = 1'b1;
                bubble_id_o = 1'b1;
                inc_bubble  = 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (stall_all_o),
        .count_o (stall_cnt_o)
    );

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_bubble_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (inc_bubble),
        .count_o (bubble_cnt_o)
    );

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .inc_i   (flush_if_o),
        .count_o (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural model, on a 16-bit and a 4-bit counter build.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       forward_en;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_two_src, id_uses_src1;
    logic       exe_wb_en, exe_mem_read, mem_wb_en;
    logic       branch_taken, mem_rd_en, mem_wr_en, mem_ready;

    logic        a_freeze_if, a_freeze_id, a_stall_all, a_flush_if, a_bubble_id;
    logic [15:0] a_stall_cnt, a_bubble_cnt, a_flush_cnt;
    logic        b_freeze_if, b_freeze_id, b_stall_all, b_flush_if, b_bubble_id;
    logic [3:0]  b_stall_cnt, b_bubble_cnt, b_flush_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_W(4), .CNT_W(16)) u_dut (
        .clk_i(clk), .rst_i(rst), .forward_en_i(forward_en),
        .id_src1_i(id_src1), .id_src2_i(id_src2), .id_two_src_i(id_two_src),
        .id_uses_src1_i(id_uses_src1), .exe_dest_i(exe_dest), .exe_wb_en_i(exe_wb_en),
        .exe_mem_read_i(exe_mem_read), .mem_dest_i(mem_dest), .mem_wb_en_i(mem_wb_en),
        .branch_taken_i(branch_taken), .mem_rd_en_i(mem_rd_en), .mem_wr_en_i(mem_wr_en),
        .mem_ready_i(mem_ready),
        .freeze_if_o(a_freeze_if), .freeze_id_o(a_freeze_id), .stall_all_o(a_stall_all),
        .flush_if_o(a_flush_if), .bubble_id_o(a_bubble_id),
        .stall_cnt_o(a_stall_cnt), .bubble_cnt_o(a_bubble_cnt), .flush_cnt_o(a_flush_cnt)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(4), .CNT_W(4)) u_dut_small (
        .clk_i(clk), .rst_i(rst), .forward_en_i(forward_en),
        .id_src1_i(id_src1), .id_src2_i(id_src2), .id_two_src_i(id_two_src),
        .id_uses_src1_i(id_uses_src1), .exe_dest_i(exe_dest), .exe_wb_en_i(exe_wb_en),
        .exe_mem_read_i(exe_mem_read), .mem_dest_i(mem_dest), .mem_wb_en_i(mem_wb_en),
        .branch_taken_i(branch_taken), .mem_rd_en_i(mem_rd_en), .mem_wr_en_i(mem_wr_en),
        .mem_ready_i(mem_ready),
        .freeze_if_o(b_freeze_if), .freeze_id_o(b_freeze_id), .stall_all_o(b_stall_all),
        .flush_if_o(b_flush_if), .bubble_id_o(b_bubble_id),
        .stall_cnt_o(b_stall_cnt), .bubble_cnt_o(b_bubble_cnt), .flush_cnt_o(b_flush_cnt)
    );

    // Behavioural model: a wait continues exactly as long as the previous cycle stalled.
    logic m_prev_stall = 1'b0;
    int   m_stall_n = 0, m_bubble_n = 0, m_flush_n = 0;
    logic e_stall, e_flush, e_bubble_case, e_hazard;
    logic e_freeze_if, e_freeze_id, e_bubble_id;

    function automatic logic hits(input logic [3:0] src);
        logic exe_hit, mem_hit;
        exe_hit = exe_wb_en && (src == exe_dest) && (!forward_en || exe_mem_read);
        mem_hit = !forward_en && mem_wb_en && (src == mem_dest);
        return exe_hit || mem_hit;
    endfunction

    always_comb begin
        e_hazard      = (id_uses_src1 && hits(id_src1)) || (id_two_src && hits(id_src2));
        e_stall       = !rst && !mem_ready && ((mem_rd_en || mem_wr_en) || m_prev_stall);
        e_flush       = !rst && !e_stall && branch_taken;
        e_bubble_case = !rst && !e_stall && !branch_taken && e_hazard;
        e_freeze_if   = e_stall || e_bubble_case;
        e_freeze_id   = e_stall;
        e_bubble_id   = e_flush || e_bubble_case;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_prev_stall <= 1'b0;
            m_stall_n    <= 0;
            m_bubble_n   <= 0;
            m_flush_n    <= 0;
        end else begin
            m_prev_stall <= e_stall;
            m_stall_n    <= m_stall_n + int'(e_stall);
            m_bubble_n   <= m_bubble_n + int'(e_bubble_case);
            m_flush_n    <= m_flush_n + int'(e_flush);
        end
    end

    function automatic int sat(input int n, input int max);
        return (n > max) ? max : n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model freeze_if",  32'(a_freeze_if), 32'(e_freeze_if));
        check("model freeze_id",  32'(a_freeze_id), 32'(e_freeze_id));
        check("model stall_all",  32'(a_stall_all), 32'(e_stall));
        check("model flush_if",   32'(a_flush_if),  32'(e_flush));
        check("model bubble_id",  32'(a_bubble_id), 32'(e_bubble_id));
        check("model stall_cnt",  32'(a_stall_cnt),  32'(sat(m_stall_n, 65535)));
        check("model bubble_cnt", 32'(a_bubble_cnt), 32'(sat(m_bubble_n, 65535)));
        check("model flush_cnt",  32'(a_flush_cnt),  32'(sat(m_flush_n, 65535)));
        check("model4 controls",
              32'({b_freeze_if, b_freeze_id, b_stall_all, b_flush_if, b_bubble_id}),
              32'({e_freeze_if, e_freeze_id, e_stall, e_flush, e_bubble_id}));
        check("model4 stall_cnt",  32'(b_stall_cnt),  32'(sat(m_stall_n, 15)));
        check("model4 bubble_cnt", 32'(b_bubble_cnt), 32'(sat(m_bubble_n, 15)));
        check("model4 flush_cnt",  32'(b_flush_cnt),  32'(sat(m_flush_n, 15)));
    end

    task automatic idle();
        forward_en = 0; id_src1 = 0; id_src2 = 0; id_two_src = 0; id_uses_src1 = 0;
        exe_dest = 0; exe_wb_en = 0; exe_mem_read = 0; mem_dest = 0; mem_wb_en = 0;
        branch_taken = 0; mem_rd_en = 0; mem_wr_en = 0; mem_ready = 0;
        exe_dest = 4'd9; mem_dest = 4'd9;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        tick();
        rst = 0;
    endtask

    task automatic set_hazard();
        exe_wb_en = 1; exe_dest = 4'd3; id_src1 = 4'd3; id_uses_src1 = 1;
    endtask

    initial begin
        rst = 1;
        idle();
        mem_rd_en = 1;
        branch_taken = 1;
        @(negedge clk);
        check("reset controls",
              32'({a_freeze_if, a_freeze_id, a_stall_all, a_flush_if, a_bubble_id}), 0);
        tick();
        rst = 0;
        idle();
        @(negedge clk);
        check("reset counters", 32'({a_stall_cnt, a_bubble_cnt}), 0);
        check("reset flush_cnt", 32'(a_flush_cnt), 0);
        tick();

        // Hazard without forwarding
        set_hazard();
        @(negedge clk);
        check("t1 freeze_if", 32'(a_freeze_if), 1);
        check("t1 bubble_id", 32'(a_bubble_id), 1);
        check("t1 freeze_id", 32'(a_freeze_id), 0);
        check("t1 bubble_cnt before", 32'(a_bubble_cnt), 0);
        tick();
        idle();
        @(negedge clk);
        check("t1 bubble_cnt after", 32'(a_bubble_cnt), 1);
        tick();

        // Forwarding hides ALU results but not a load
        set_hazard();
        forward_en = 1;
        @(negedge clk);
        check("t2 fwd no load", 32'({a_freeze_if, a_bubble_id}), 0);
        tick();
        exe_mem_read = 1;
        @(negedge clk);
        check("t2 fwd load-use", 32'({a_freeze_if, a_bubble_id}), 3);
        tick();

        // Branch beats hazard
        do_reset();
        set_hazard();
        branch_taken = 1;
        @(negedge clk);
        check("t3 flush/bubble/freeze_if",
              32'({a_flush_if, a_bubble_id, a_freeze_if}), 32'b110);
        tick();
        idle();
        @(negedge clk);
        check("t3 flush_cnt", 32'(a_flush_cnt), 1);
        check("t3 bubble_cnt", 32'(a_bubble_cnt), 0);
        tick();

        // Four-cycle load wait
        do_reset();
        mem_rd_en = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4 wait stall/freeze",
                  32'({a_stall_all, a_freeze_if, a_freeze_id}), 32'b111);
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        check("t4 ready cycle", 32'({a_stall_all, a_freeze_if, a_freeze_id}), 0);
        tick();
        idle();
        @(negedge clk);
        check("t4 back in run", 32'(a_stall_all), 0);
        check("t4 stall_cnt", 32'(a_stall_cnt), 4);
        tick();

        // Branch held across a two-cycle wait
        do_reset();
        mem_rd_en = 1;
        branch_taken = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t5 flush held off", 32'(a_flush_if), 0);
            tick();
        end
        mem_ready = 1;
        @(negedge clk);
        check("t5 flush on ready", 32'({a_flush_if, a_stall_all}), 32'b10);
        tick();
        idle();
        @(negedge clk);
        check("t5 flush_cnt", 32'(a_flush_cnt), 1);
        tick();

        // Saturation and reset during a wait
        do_reset();
        mem_rd_en = 1;
        repeat (20) tick();
        @(negedge clk);
        check("t6 stall_cnt 4-bit saturated", 32'(b_stall_cnt), 15);
        check("t6 stall_cnt 16-bit", 32'(a_stall_cnt), 20);
        tick();
        rst = 1;
        @(negedge clk);
        check("t6 reset drops stall", 32'({a_stall_all, b_stall_all}), 0);
        tick();
        rst = 0;
        mem_rd_en = 0;
        @(negedge clk);
        check("t6 run after reset", 32'(b_stall_all), 0);
        check("t6 counters cleared",
              32'({b_stall_cnt, b_bubble_cnt, b_flush_cnt, a_stall_cnt}), 0);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            rst          = ($urandom_range(0, 99) == 0);
            forward_en   = 1'($urandom_range(0, 1));
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            exe_dest     = 4'($urandom_range(0, 3));
            mem_dest     = 4'($urandom_range(0, 3));
            id_two_src   = 1'($urandom_range(0, 1));
            id_uses_src1 = 1'($urandom_range(0, 1));
            exe_wb_en    = 1'($urandom_range(0, 1));
            exe_mem_read = 1'($urandom_range(0, 1));
            mem_wb_en    = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 5) == 0);
            mem_rd_en    = ($urandom_range(0, 5) == 0);
            mem_wr_en    = ($urandom_range(0, 7) == 0);
            mem_ready    = ($urandom_range(0, 3) == 0);
            tick();
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
